audio_sample_logger: RTL and testbench
======================================

# audio_sample_logger

Parametrised multi-channel audio capture buffer for the equalizer datapath. It samples frames of NUM_CH signed channels on a valid strobe, optionally decimates them, and stores whole frames in an on-chip FIFO. A host or debug port drains the FIFO one channel word at a time. It supports continuous or one-shot capture and replaces ad-hoc per-clock sample dumping with a bounded, flow-controlled buffer.

## Interface
- NUM_CH, 2, channels per frame (1..8)
- DATA_W, 16, bits per signed channel sample
- DEPTH, 64, FIFO depth in frames; power of 2, at least 4
- DECIM_W, 8, width of decimation ratio input
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-high reset
- smpl_vld  in  1  one-cycle strobe; smpl_data holds a complete frame
- smpl_data  in  NUM_CH*DATA_W  frame; channel 0 in LSBs
- decim  in  DECIM_W  keep 1 of every decim+1 accepted frames; 0 = keep all
- oneshot  in  1  1 = stop when full; 0 = continuous
- arm  in  1  pulse: flush FIFO, clear ovf, enter CAPTURE
- stop  in  1  pulse: CAPTURE -> IDLE
- rd_en  in  1  pop one channel word
- rd_data  out  DATA_W  channel word
- rd_ch  out  $clog2(NUM_CH) (min 1)  channel index of rd_data
- rd_vld  out  1  rd_data/rd_ch valid, one cycle
- empty  out  1  no frames stored
- full  out  1  DEPTH frames stored
- count  out  $clog2(DEPTH)+1  frames stored
- ovf  out  1  sticky; a kept frame was dropped
- done  out  1  high in DONE state
- peak  out  NUM_CH*DATA_W  per-channel peak magnitude (see Configuration)
- peak_clr  in  1  clear peak registers

## Operation
- States:
  - IDLE (reset state)
  - CAPTURE
  - DONE
- Transitions:
  - arm: IDLE/DONE/CAPTURE -> CAPTURE. A restart from CAPTURE is allowed. Arm flushes the FIFO (pointers, count and read channel index cleared) and clears ovf and the decimation counter.
  - stop in CAPTURE -> IDLE. The FIFO contents are kept.
  - oneshot=1 and a write makes count reach DEPTH -> DONE.
  - arm and stop in the same cycle: arm wins.
- Decimation:
  - A counter runs on each smpl_vld in CAPTURE.
  - A frame is kept when the counter is 0. The counter then wraps at decim.
  - decim is sampled live. A counter value above decim wraps to 0 on the next strobe.
- Write:
  - A kept frame is written when not full.
  - If full, the frame is dropped and ovf is set. This only happens in continuous mode.
  - Exception: the write is accepted if the same cycle pops the last channel of the head frame.
- Read:
  - rd_en with empty=0 outputs channel rd_ch of the head frame.
  - The channel index increments. After channel NUM_CH-1 the frame is popped and the index returns to 0.
  - rd_en with empty=1 is ignored: rd_vld stays 0 and nothing changes.
- Reading is allowed in every state.
- smpl_vld outside CAPTURE is ignored.

## Timing
- Reset values:
  - state IDLE
  - count 0, empty 1, full 0
  - ovf 0, done 0
  - rd_vld 0, rd_data 0, rd_ch 0
  - peak 0
- Write latency: a frame kept at edge N is included in count, empty and full after edge N. It is readable by rd_en in cycle N+1.
- Read latency: rd_en sampled at edge N gives rd_vld=1 with rd_data/rd_ch after edge N, held for that one cycle.
- Pop timing: the pop on the last channel updates count at the same edge.
- Simultaneous push and pop of a frame: count unchanged.
- Pointers wrap modulo DEPTH.
- rst mid-operation aborts any capture and read immediately and restores all reset values.

## Configuration
- Macro: AUDIO_LOGGER_PEAK_DET_EN.
- Defined:
  - Every smpl_vld in CAPTURE, before decimation, updates each channel peak to max(peak, |sample|).
  - |most negative value| saturates to 2^(DATA_W-1)-1.
  - peak_clr zeroes all peaks next edge. It wins over a same-cycle sample.
- Undefined: peak is tied to 0, peak_clr is ignored, and no peak registers are synthesized.

## Test plan
- Reset, then arm with decim=0 and oneshot=0. Push 3 frames of {L=0x1234, R=0xFEDC}. Expect count=3. Then 6 rd_en pulses -> rd_data 0x1234/0xFEDC alternating, rd_ch 0/1, empty=1 at the end.
- decim=3, 16 strobes with data equal to the strobe index -> 4 frames stored, holding indices 0, 4, 8, 12.
- oneshot=1, push 70 frames with DEPTH=64 -> done=1 after frame 64, count=64, ovf=0. The remaining frames are ignored.
- Continuous mode at full, push 1 more frame -> ovf=1, count=64. Repeat with the last-channel pop in the same cycle -> write accepted, count=64, ovf unchanged.
- With the macro defined, push samples L=-32768 and L=100 -> peak L=0x7FFF. Assert peak_clr together with a new strobe -> peak=0.
- Assert rst during readout mid-frame -> all outputs at reset values, rd_ch=0, and a following arm captures normally.

Source files
------------

// File: rtl/audio_sample_logger.sv
// Multi-channel audio capture FIFO: decimated frame capture, per-word host readout.
// Optional per-channel peak detector enabled by AUDIO_LOGGER_PEAK_DET_EN.
module audio_sample_logger #(
    parameter  int NUM_CH  = 2,
    parameter  int DATA_W  = 16,
    parameter  int DEPTH   = 64,
    parameter  int DECIM_W = 8,
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smpl_vld,
    input  logic [NUM_CH*DATA_W-1:0] smpl_data,
    input  logic [DECIM_W-1:0]       decim,
    input  logic                     oneshot,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CHW-1:0]           rd_ch,
    output logic                     rd_vld,
    output logic                     empty,
    output logic                     full,
    output logic [AW:0]              count,
    output logic                     ovf,
    output logic                     done,
    output logic [NUM_CH*DATA_W-1:0] peak,
    input  logic                     peak_clr
);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t                       r_state;
    logic [NUM_CH*DATA_W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]                r_wptr, r_rptr;
    logic [AW:0]                  r_count;
    logic [CHW-1:0]               r_ch;
    logic [DECIM_W-1:0]           r_dcnt;
    logic                         r_ovf;
    logic                         r_done;

    logic [NUM_CH-1:0][DATA_W-1:0] w_head;
    logic                          w_empty, w_full, w_strobe, w_keep, w_rd, w_pop, w_wr;
    logic [AW:0]                   w_cnt_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    // Arm flushes the FIFO, so a same-cycle sample or read is discarded.
    assign w_strobe  = smpl_vld && (r_state == S_CAPTURE) && !arm;
    assign w_keep    = w_strobe && (r_dcnt == '0);
    assign w_rd      = rd_en && !w_empty && !arm;
    assign w_pop     = w_rd && (r_ch == LAST_CH);
    assign w_wr      = w_keep && (!w_full || w_pop);
    assign w_cnt_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    assign w_head    = r_mem[r_rptr];

    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_count;
    assign ovf   = r_ovf;
    assign done  = r_done;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= smpl_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ch    <= '0;
            r_dcnt  <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
            rd_ch   <= '0;
        end else begin
            rd_vld <= w_rd;
            if (w_rd) begin
                rd_data <= w_head[r_ch];
                rd_ch   <= r_ch;
            end
            if (arm) begin
                r_state <= S_CAPTURE;
                r_done  <= 1'b0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_ch    <= '0;
                r_dcnt  <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_rd)  r_ch   <= w_pop ? '0 : r_ch + 1'b1;
                if (w_pop) r_rptr <= r_rptr + 1'b1;
                if (w_wr)  r_wptr <= r_wptr + 1'b1;
                if (w_keep && !w_wr) r_ovf <= 1'b1;
                r_count <= w_cnt_nxt;
                // Counter above a live-lowered decim falls back to 0 on the next strobe.
                if (w_strobe) r_dcnt <= (r_dcnt >= decim) ? '0 : r_dcnt + 1'b1;
                if (r_state == S_CAPTURE) begin
                    if (oneshot && w_wr && (w_cnt_nxt == FULL_CNT)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (stop) begin
                        r_state <= S_IDLE;
                    end
                end
            end
        end
    end

`ifdef AUDIO_LOGGER_PEAK_DET_EN
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    logic w_pk_strobe;
    assign w_pk_strobe = smpl_vld && (r_state == S_CAPTURE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_peak
        logic [DATA_W-1:0] w_s, w_mag, r_pk;
        assign w_s   = smpl_data[c*DATA_W +: DATA_W];
        assign w_mag = (w_s == SMIN) ? SMAX : (w_s[DATA_W-1] ? (~w_s + 1'b1) : w_s);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                              r_pk <= '0;
            else if (peak_clr)                    r_pk <= '0;
            else if (w_pk_strobe && w_mag > r_pk) r_pk <= w_mag;
        end
        assign peak[c*DATA_W +: DATA_W] = r_pk;
    end
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = peak_clr;
    assign peak = '0;
`endif

endmodule

// File: tb/tb_audio_sample_logger.sv
// Directed self-checking bench for audio_sample_logger (NUM_CH=2, DATA_W=16, DEPTH=64).
module tb_audio_sample_logger;
    logic        clk = 1'b0, rst = 1'b1;
    logic        smpl_vld = 1'b0, oneshot = 1'b0, arm = 1'b0, stop = 1'b0;
    logic        rd_en = 1'b0, peak_clr = 1'b0;
    logic [31:0] smpl_data = '0;
    logic [7:0]  decim = '0;
    logic [15:0] rd_data;
    logic        rd_ch, rd_vld, empty, full, ovf, done;
    logic [6:0]  count;
    logic [31:0] peak;
    int          checks = 0, failures = 0;

    audio_sample_logger #(.NUM_CH(2), .DATA_W(16), .DEPTH(64), .DECIM_W(8)) dut (
        .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_data(smpl_data), .decim(decim),
        .oneshot(oneshot), .arm(arm), .stop(stop), .rd_en(rd_en), .rd_data(rd_data),
        .rd_ch(rd_ch), .rd_vld(rd_vld), .empty(empty), .full(full), .count(count),
        .ovf(ovf), .done(done), .peak(peak), .peak_clr(peak_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] f);
        smpl_data = f;
        smpl_vld  = 1'b1;
        tick();
        smpl_vld  = 1'b0;
    endtask

    task automatic do_arm(input logic [7:0] d, input logic os);
        decim   = d;
        oneshot = os;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    task automatic rd_word(input string tag, input logic [15:0] exp_d, input logic exp_ch);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 64'(rd_vld), 1);
        chk({tag, "_data"}, 64'(rd_data), 64'(exp_d));
        chk({tag, "_ch"}, 64'(rd_ch), 64'(exp_ch));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 64'(count), 0);
        chk({tag, "_empty"}, 64'(empty), 1);
        chk({tag, "_full"}, 64'(full), 0);
        chk({tag, "_ovf"}, 64'(ovf), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_rdvld"}, 64'(rd_vld), 0);
        chk({tag, "_rddata"}, 64'(rd_data), 0);
        chk({tag, "_rdch"}, 64'(rd_ch), 0);
        chk({tag, "_peak"}, 64'(peak), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // Basic capture and word-by-word readout
        do_arm(8'd0, 1'b0);
        repeat (3) push(32'hFEDC_1234);
        chk("t1_count", 64'(count), 3);
        chk("t1_empty", 64'(empty), 0);
        for (int i = 0; i < 6; i++)
            rd_word("t1_rd", (i % 2 == 1) ? 16'hFEDC : 16'h1234, (i % 2) == 1);
        chk("t1_empty_end", 64'(empty), 1);
        chk("t1_count_end", 64'(count), 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_on_empty_vld", 64'(rd_vld), 0);

        // Stop returns to IDLE; strobes are then ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push(32'h5555_AAAA);
        chk("idle_ignore_count", 64'(count), 0);

        // Decimation 1 of 4
        do_arm(8'd3, 1'b0);
        for (int i = 0; i < 16; i++) push({16'(i + 100), 16'(i)});
        chk("dec_count", 64'(count), 4);
        for (int k = 0; k < 4; k++) begin
            rd_word("dec_l", 16'(k * 4), 1'b0);
            rd_word("dec_r", 16'(k * 4 + 100), 1'b1);
        end

        // One-shot stops at full
        do_arm(8'd0, 1'b1);
        for (int i = 0; i < 70; i++) begin
            push({16'h0, 16'(i)});
            if (i == 62) chk("os_done_early", 64'(done), 0);
            if (i == 63) chk("os_done", 64'(done), 1);
        end
        chk("os_count", 64'(count), 64);
        chk("os_full", 64'(full), 1);
        chk("os_ovf", 64'(ovf), 0);
        rd_word("os_first", 16'h0000, 1'b0);

        // Continuous overflow, then push accepted with same-cycle last-channel pop
        do_arm(8'd0, 1'b0);
        for (int i = 0; i < 64; i++) push({16'hBEEF, 16'(i)});
        chk("ct_full", 64'(full), 1);
        chk("ct_ovf_pre", 64'(ovf), 0);
        push(32'h1111_2222);
        chk("ct_ovf", 64'(ovf), 1);
        chk("ct_ovf_count", 64'(count), 64);
        do_arm(8'd0, 1'b0);
        chk("arm_clr_ovf", 64'(ovf), 0);
        chk("arm_clr_empty", 64'(empty), 1);
        for (int i = 0; i < 64; i++) push({16'hBEEF, 16'(i)});
        rd_word("pp_ch0", 16'h0000, 1'b0);
        smpl_data = 32'hCAFE_5555;
        smpl_vld  = 1'b1;
        rd_en     = 1'b1;
        tick();
        smpl_vld  = 1'b0;
        rd_en     = 1'b0;
        chk("pp_rd_data", 64'(rd_data), 64'hBEEF);
        chk("pp_rd_ch", 64'(rd_ch), 1);
        chk("pp_count", 64'(count), 64);
        chk("pp_ovf", 64'(ovf), 0);
        rd_en = 1'b1;
        repeat (126) tick();
        rd_en = 1'b0;
        chk("pp_drain_count", 64'(count), 1);
        rd_word("pp_new_l", 16'h5555, 1'b0);
        rd_word("pp_new_r", 16'hCAFE, 1'b1);
        chk("pp_empty", 64'(empty), 1);

        // Peak detector
        do_arm(8'd0, 1'b0);
        push({16'd5, 16'h8000});
        push({16'hFFFF, 16'd100});
`ifdef AUDIO_LOGGER_PEAK_DET_EN
        chk("peak_val", 64'(peak), 64'h0005_7FFF);
        peak_clr = 1'b1;
        push(32'h0007_0007);
        peak_clr = 1'b0;
        chk("peak_clr", 64'(peak), 0);
`else
        chk("peak_off", 64'(peak), 0);
`endif

        // Asynchronous reset mid-frame readout
        do_arm(8'd0, 1'b0);
        push(32'h2222_1111);
        push(32'h4444_3333);
        rd_word("mr_ch0", 16'h1111, 1'b0);
        #2 rst = 1'b1;
        #1 chk_reset("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        do_arm(8'd0, 1'b0);
        push(32'h6666_5555);
        chk("post_rst_count", 64'(count), 1);
        rd_word("post_l", 16'h5555, 1'b0);
        rd_word("post_r", 16'h6666, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
